// File: rtl/cga_pkg.sv
// Shared definitions for the CGA video RAM arbiter:
// FSM encoding, window base and the captured CPU command.
package cga_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [19:0] CGA_BASE = 20'hB8000;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
  } cpu_cmd_t;

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchronizer and registered falling-edge
// detect for the asynchronous ISA memr/memw strobes.
module isa_strobe_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic memr_l,
  input  logic memw_l,
  output logic memr_s,
  output logic memw_s,
  output logic memr_fall,
  output logic memw_fall
);

  logic [1:0] r_meta;
  logic [1:0] w_meta;
  logic       r_prev;
  logic       w_prev;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_meta <= 2'b11;
      w_meta <= 2'b11;
      r_prev <= 1'b1;
      w_prev <= 1'b1;
    end else begin
      r_meta <= {r_meta[0], memr_l};
      w_meta <= {w_meta[0], memw_l};
      r_prev <= r_meta[1];
      w_prev <= w_meta[1];
    end
  end

  assign memr_s    = r_meta[1];
  assign memw_s    = w_meta[1];
  assign memr_fall = r_prev & ~r_meta[1];
  assign memw_fall = w_prev & ~w_meta[1];

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the single-port video RAM between display fetch
// (always wins) and queued ISA CPU accesses in granted slots.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int USE_BUS_WAIT = 1,
  parameter int RAM_LATENCY  = 1,
  parameter int MAX_WAIT     = 63
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic              bus_mem_cs,
  input  logic              bus_memr_l,
  input  logic              bus_memw_l,
  input  logic [DATA_W-1:0] bus_d,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_dir,
  output logic              bus_rdy,
  input  logic [ADDR_W-1:0] vid_a,
  input  logic              vid_req,
  input  logic              isa_slot,
  output logic [DATA_W-1:0] vid_data,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [5:0] WAIT_LIM = 6'(MAX_WAIT);
  localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

  logic [2:0] state;
  logic [2:0] state_nx;
  cpu_cmd_t   cmd_q;
  logic [5:0] wait_cnt;
  logic [1:0] lat_cnt;

  logic memr_s;
  logic memw_s;
  logic memr_fall;
  logic memw_fall;
  logic cmd_det;
  logic busy;
  logic rd_capture;

  isa_strobe_sync u_sync (
    .clk       (clk),
    .reset_l   (reset_l),
    .memr_l    (bus_memr_l),
    .memw_l    (bus_memw_l),
    .memr_s    (memr_s),
    .memw_s    (memw_s),
    .memr_fall (memr_fall),
    .memw_fall (memw_fall)
  );

  assign cmd_det = bus_mem_cs & (memr_fall | memw_fall);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_det) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (isa_slot && !vid_req)
          state_nx = ST_ACCESS;
        else if (!cmd_q.write && memr_s)
          state_nx = ST_IDLE;
        else if (wait_cnt == WAIT_LIM)
          state_nx = ST_DONE;
      end
      ST_ACCESS: state_nx = ST_LATCH;
      ST_LATCH: begin
        if (cmd_q.write || lat_cnt == LAT_LAST)
          state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (memr_s && memw_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rd_capture = (state == ST_LATCH) && !cmd_q.write &&
                      (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      bus_out   <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && cmd_det) begin
        // both strobes falling together resolve to a write
        cmd_q.write <= memw_fall;
        cmd_q.addr  <= bus_a;
        mem_wdata   <= bus_d;
      end
      if (state == ST_IDLE)
        wait_cnt <= '0;
      else if (state == ST_WAIT && wait_cnt != 6'h3f)
        wait_cnt <= wait_cnt + 6'd1;
      if (state == ST_ACCESS)
        lat_cnt <= '0;
      else if (state == ST_LATCH)
        lat_cnt <= lat_cnt + 2'd1;
      if (rd_capture)
        bus_out <= mem_rdata;
    end
  end

  assign mem_a  = (state == ST_ACCESS) ? cmd_q.addr : vid_a;
  assign mem_we = (state == ST_ACCESS) & cmd_q.write;

  assign vid_data = mem_rdata;
  assign bus_dir  = bus_mem_cs & ~bus_memr_l;

  assign busy = (state == ST_WAIT) || (state == ST_ACCESS) ||
                (state == ST_LATCH) ||
                (state == ST_IDLE && cmd_det);

  assign bus_rdy = (USE_BUS_WAIT != 0) ? ~busy : 1'b1;

`ifndef SYNTHESIS
  a_no_vid_in_access : assert property (
    @(posedge clk) disable iff (!reset_l)
    !(state == ST_ACCESS && vid_req)
  );
`endif

endmodule

// File: doc/cga_vram_arbiter.md
# cga_vram_arbiter

Upstream neighbour of the CGA display core: owns the single-port video RAM and shares it between the ISA memory bus (CPU reads/writes of B8000–BFFFF) and the display fetch path. Display fetches always win. CPU accesses are queued and executed only in sequencer-granted ISA slots, with optional ISA wait-state generation. It feeds `ram_d` into the display core and produces `bus_out`/`bus_dir`/`bus_rdy` for the memory side of the bus.

## Interface
Parameters:
- `USE_BUS_WAIT`, 1: 1 = drive `bus_rdy` low until a CPU access completes; 0 = `bus_rdy` tied high, writes posted.
- `RAM_LATENCY`, 1: cycles from `mem_a` valid to `mem_rdata` valid (1 or 2).
- `MAX_WAIT`, 63: slot-wait watchdog limit, in clk cycles.

Ports:
- `clk` in 1: system clock (28.636 MHz domain).
- `reset_l` in 1: reset, asynchronous, active-low.
- `bus_a` in 15: ISA address offset within the 32 KB window.
- `bus_mem_cs` in 1: decoded window select.
- `bus_memr_l`, `bus_memw_l` in 1 each: raw ISA strobes, asynchronous.
- `bus_d` in 8: ISA write data.
- `bus_out` out 8: CPU read data (latched).
- `bus_dir` out 1: high while `bus_mem_cs & ~bus_memr_l`.
- `bus_rdy` out 1: ISA ready.
- `vid_a` in 15: display fetch address.
- `vid_req` in 1: display fetch this cycle (sequencer `vram_read`).
- `isa_slot` in 1: CPU slot permitted (sequencer `isa_op_enable`).
- `vid_data` out 8: display fetch data, equal to `mem_rdata` delayed 0 cycles.
- `mem_a` out 15, `mem_we` out 1 (active-high), `mem_wdata` out 8, `mem_rdata` in 8: RAM port.

## Operation
- Strobes pass through a 2-flop synchronizer. A command is detected on the synced falling edge of memr or memw while `bus_mem_cs` is high. `bus_a` and `bus_d` are captured in the same cycle.
- Memr and memw both falling in the same cycle: treated as a write.
- FSM states:
  - IDLE: on command → WAIT_SLOT.
  - WAIT_SLOT: when `isa_slot & ~vid_req` → ACCESS. When the wait counter reaches `MAX_WAIT` → DONE with no RAM access; `bus_out` is unchanged.
  - ACCESS: drive `mem_a`, assert `mem_we` (writes) for exactly 1 cycle, then → LATCH.
  - LATCH: a read captures `mem_rdata` into `bus_out` after `RAM_LATENCY` cycles; a write leaves immediately. Then → DONE.
  - DONE: `bus_rdy` high; → IDLE when both synced strobes are high.
- Mux: `mem_a = vid_a` whenever the FSM is not in ACCESS. `vid_req` in ACCESS is a sequencer protocol violation and must not occur; assert it in simulation.
- `bus_rdy` (`USE_BUS_WAIT`=1) is low from the detect cycle through LATCH, and high otherwise.
- Strobe released before service:
  - a write still completes (posted);
  - a read is dropped and the FSM returns to IDLE from WAIT_SLOT.
- Wait counter: 6 bits, clears in IDLE, saturates.

## Timing
- Reset values: `bus_out`=00, `bus_rdy`=1, `mem_we`=0, `mem_wdata`=00, `mem_a`=`vid_a`, FSM=IDLE, synchronizers=1.
- Reset asserted mid-access: `mem_we` drops asynchronously and any pending command is discarded.
- Detect latency: 2 cycles after a strobe edge, plus 1 cycle for the edge register.
- Best-case read (slot already open): strobe edge → `bus_out` valid in 3 + 1 + `RAM_LATENCY` + 1 cycles.
- `bus_rdy` rises in the same cycle `bus_out` becomes valid.
- `vid_data` is combinationally `mem_rdata`, so display timing is unchanged from direct RAM attachment.

## Structure
- Shared `cga_pkg`: FSM state encoding (IDLE, WAIT_SLOT, ACCESS, LATCH, DONE) and the CGA window base B8000.
- One sub-module, `isa_strobe_sync`: 2-flop synchronizer plus falling-edge detect for both strobes, reset to 1.

## Test plan
- **Read, slot open:** RAM[0x0123]=5A, `isa_slot`=1, memr low → `bus_rdy` low, then high with `bus_out`=5A at the cycle count above; `mem_we` never asserted.
- **Write during video burst:** `vid_req` high for 10 cycles, memw A=0x7FFF D=C3 → `mem_we` pulses once after `vid_req` falls; RAM[0x7FFF]=C3; `vid_data` undisturbed.
- **Watchdog:** `isa_slot` held 0, memr low → `bus_rdy` returns high after 63 cycles; `bus_out` unchanged; no RAM access.
- **Early release:** memw pulse of 2 cycles with `isa_slot`=0 → write lands at the next slot. Same test with memr → no access; FSM back in IDLE.
- **Simultaneous strobes / reset:** memr and memw falling together → write performed. `reset_l` low during ACCESS → `mem_we` low immediately, `bus_rdy`=1, FSM=IDLE.
- **`USE_BUS_WAIT`=0:** `bus_rdy` constantly 1 across all of the above.
